// File: rtl/img_line_buffer_n.sv
// img_line_buffer_n: keeps the last LINES rows and emits a LINES+1 pixel column per accepted pixel.
// Optional IMG_LINE_BUF_BORDER_REP_EN replicates the oldest filled row into unfilled top taps.
module img_line_buffer_n #(
  parameter int WIDTH = 8,
  parameter int COL   = 752,
  parameter int LINES = 2,
  parameter int CW    = 10
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     sof,
  input  logic [WIDTH-1:0]         din,
  input  logic                     valid_in,
  output logic [WIDTH*(LINES+1)-1:0] dout,
  output logic                     valid_out,
  output logic [CW-1:0]            col_out,
  output logic                     eol_out
);
  localparam int FW = $clog2(LINES + 1);
  localparam int AW = COL > 1 ? $clog2(COL) : 1;
  logic [CW-1:0] col, c;
  logic [AW-1:0] a;
  logic [FW-1:0] fill, fill_c, fill_n;
  logic wrap, vo;
  logic [WIDTH-1:0] ram [LINES][COL];
  logic [WIDTH-1:0] tap [LINES+1];
  logic [WIDTH-1:0] sel [LINES+1];
  // sof restarts the frame on the very pixel that carries it
  always_comb begin
    c = sof ? '0 : col;
    a = c[AW-1:0];
    fill_c = sof ? '0 : fill;
    wrap = c == CW'(COL - 1);
    fill_n = (wrap && fill_c != FW'(LINES)) ? fill_c + 1'b1 : fill_c;
    tap[0] = din;
    for (int k = 0; k < LINES; k++) tap[k+1] = ram[k][a];
  end
`ifdef IMG_LINE_BUF_BORDER_REP_EN
  always_comb begin
    for (int k = 0; k <= LINES; k++) sel[k] = (k > int'(fill_c)) ? tap[fill_c] : tap[k];
  end
  assign vo = valid_in;
`else
  always_comb begin
    for (int k = 0; k <= LINES; k++) sel[k] = tap[k];
  end
  assign vo = valid_in && fill_c == FW'(LINES);
`endif
  // read-before-write shift cascade: every row moves down one line at this column
  always_ff @(posedge clk) begin
    if (valid_in) begin
      ram[0][a] <= din;
      for (int k = 1; k < LINES; k++) ram[k][a] <= ram[k-1][a];
    end
  end
  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      col       <= '0;
      fill      <= '0;
      dout      <= '0;
      valid_out <= 1'b0;
      col_out   <= '0;
      eol_out   <= 1'b0;
    end else begin
      valid_out <= vo;
      if (valid_in) begin
        col     <= wrap ? '0 : c + 1'b1;
        fill    <= fill_n;
        col_out <= c;
        eol_out <= wrap;
        for (int k = 0; k <= LINES; k++) dout[k*WIDTH +: WIDTH] <= sel[k];
      end
    end
  end
endmodule

// File: tb/tb_img_line_buffer_n.sv
// tb_img_line_buffer_n: directed plus randomized stimulus checked against a frame-image model.
module tb_img_line_buffer_n;
  localparam int WIDTH = 8, COL = 4, LINES = 2, CW = 2;
  logic clk = 0, en = 0, sof = 0, valid_in = 0;
  logic [WIDTH-1:0] din = 0;
  logic [WIDTH*(LINES+1)-1:0] dout;
  logic valid_out, eol_out;
  logic [CW-1:0] col_out;
  logic sof2 = 0, v2 = 0;
  logic [7:0] din2 = 0;
  logic [15:0] dout2;
  logic vo2, eol2;
  logic [9:0] col2;
  int checks = 0, errors = 0;

  img_line_buffer_n #(.WIDTH(WIDTH), .COL(COL), .LINES(LINES), .CW(CW)) dut (
    .clk(clk), .en(en), .sof(sof), .din(din), .valid_in(valid_in),
    .dout(dout), .valid_out(valid_out), .col_out(col_out), .eol_out(eol_out));
  img_line_buffer_n #(.WIDTH(8), .COL(752), .LINES(1), .CW(10)) dut2 (
    .clk(clk), .en(en), .sof(sof2), .din(din2), .valid_in(v2),
    .dout(dout2), .valid_out(vo2), .col_out(col2), .eol_out(eol2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: the current frame kept as an image, rows indexed from the frame start
  int row = 0, mcol = 0;
  logic [7:0] img [8][COL];
  logic live = 0, e_valid = 0, e_eol = 0;
  logic [CW-1:0] e_col = 0;
  logic [7:0] e_dout [LINES+1];
  logic known [LINES+1];
  always @(posedge clk) begin
    live = 1;
    if (!en) begin
      row = 0; mcol = 0; e_valid = 0; e_col = 0; e_eol = 0;
      for (int k = 0; k <= LINES; k++) begin e_dout[k] = 0; known[k] = 1; end
    end else begin
      e_valid = 0;
      if (valid_in) begin
        if (sof) begin row = 0; mcol = 0; end
        img[row % 8][mcol] = din;
        for (int k = 0; k <= LINES; k++) begin
`ifdef IMG_LINE_BUF_BORDER_REP_EN
          known[k] = 1;
          e_dout[k] = img[(row - (k > row ? row : k)) % 8][mcol];
`else
          known[k] = k <= row;
          if (known[k]) e_dout[k] = img[(row - k) % 8][mcol];
`endif
        end
`ifdef IMG_LINE_BUF_BORDER_REP_EN
        e_valid = 1;
`else
        e_valid = row >= LINES;
`endif
        e_col = CW'(mcol);
        e_eol = mcol == COL - 1;
        mcol++;
        if (mcol == COL) begin mcol = 0; row++; end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("valid_out", 32'(valid_out), 32'(e_valid));
      chk("col_out", 32'(col_out), 32'(e_col));
      chk("eol_out", 32'(eol_out), 32'(e_eol));
      for (int k = 0; k <= LINES; k++)
        if (known[k]) chk("dout_slice", 32'(dout[k*WIDTH +: WIDTH]), 32'(e_dout[k]));
    end
  end

  task automatic push(input int p, input logic s);
    din = 8'(p); valid_in = 1; sof = s;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    valid_in = 0; sof = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic rst_pulse();
    valid_in = 0; sof = 0; en = 0;
    @(negedge clk);
    en = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(valid_out), 0);
    chk("reset_dout", 32'(dout), 0);
    en = 1;
    for (int p = 1; p <= 12; p++) begin
      push(p, p == 1);
`ifdef IMG_LINE_BUF_BORDER_REP_EN
      if (p == 1) chk("rep_p1", 32'(dout), 32'h010101);
      if (p == 5) chk("rep_p5", 32'(dout), 32'h010105);
      if (p == 9) chk("rep_p9", 32'(dout), 32'h010509);
`else
      if (p == 8) chk("p8_novalid", 32'(valid_out), 0);
      if (p == 9) begin
        chk("p9_valid", 32'(valid_out), 1);
        chk("p9_dout", 32'(dout), 32'h010509);
        chk("p9_col", 32'(col_out), 0);
      end
      if (p == 12) begin
        chk("p12_dout", 32'(dout), 32'h04080c);
        chk("p12_eol", 32'(eol_out), 1);
      end
`endif
    end
    idle(1);
    for (int p = 1; p <= 12; p++) begin
      push(p, p == 1);
      if (p == 6) begin
        idle(3);
        chk("gap_valid", 32'(valid_out), 0);
      end
      if (p == 7) chk("gap_col", 32'(col_out), 2);
`ifndef IMG_LINE_BUF_BORDER_REP_EN
      if (p == 9) chk("gap_p9_dout", 32'(dout), 32'h010509);
`endif
    end
    for (int p = 100; p <= 111; p++) begin
      push(p, p == 100);
`ifndef IMG_LINE_BUF_BORDER_REP_EN
      if (p == 107) chk("sof_p107_valid", 32'(valid_out), 0);
      if (p == 108) chk("sof_p108_dout", 32'(dout), 32'h64686c);
`endif
    end
    for (int p = 1; p <= 10; p++) push(p, p == 1);
    rst_pulse();
    chk("midrst_valid", 32'(valid_out), 0);
    chk("midrst_col", 32'(col_out), 0);
    chk("midrst_dout", 32'(dout), 0);
    for (int p = 200; p < 212; p++) begin
      push(p, 0);
`ifndef IMG_LINE_BUF_BORDER_REP_EN
      if (p == 207) chk("rst_p8_valid", 32'(valid_out), 0);
      if (p == 208) begin
        chk("rst_p9_valid", 32'(valid_out), 1);
        chk("rst_p9_col", 32'(col_out), 0);
        chk("rst_p9_dout", 32'(dout), 32'hc8ccd0);
      end
`endif
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) < 2) rst_pulse();
      else begin
        din = 8'($urandom);
        valid_in = $urandom_range(9) < 7;
        sof = $urandom_range(49) == 0;
        @(negedge clk);
      end
    end
    idle(2);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 752; c++) begin
        din2 = 8'(c); v2 = 1; sof2 = r == 0 && c == 0;
        @(negedge clk);
`ifndef IMG_LINE_BUF_BORDER_REP_EN
        chk("l1_valid", 32'(vo2), 32'(r));
`endif
        chk("l1_col", 32'(col2), 32'(c));
        chk("l1_eol", 32'(eol2), 32'(c == 751));
        if (r == 1) chk("l1_dout", 32'(dout2), 32'({8'(c), 8'(c)}));
      end
    v2 = 0; sof2 = 0;
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
